bcd_serial_adder: RTL and testbench

BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

---
 rtl/bcd_serial_adder.sv | 151 +++++++++++++++
 tb/tb_bcd_serial_adder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_adder.sv
// Serial BCD adder: adds two packed-BCD operands one digit per clock,
// least significant digit first, and drives a 7-segment pattern for a
// selectable digit of the registered sum.
//
// state | meaning
// IDLE  | waiting for start; result registers hold their last value
// ADD   | one digit of a + b + carry computed and written per cycle
// DONE  | last digit written; done pulses on the following cycle
module bcd_serial_adder #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   cin,
    input  logic [2:0]             disp_sel,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   sum,
    output logic                   cout,
    output logic                   error,
    output logic [6:0]             seg
);

    localparam int         W    = 4 * NDIGITS;
    localparam logic [2:0] LAST = 3'(NDIGITS - 1);
    localparam logic [3:0] ND4  = 4'(NDIGITS);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           carry_q, cout_q, error_q, done_q;
    logic [2:0]     idx_q;

    logic [3:0]     a_d, b_d, digit, seg_digit;
    logic [4:0]     raw;
    logic           carry_n, bad;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (idx_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Select the current operand digits and apply the decimal correction
    always_comb begin
        a_d = '0;
        b_d = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                a_d = a_q[i*4 +: 4];
                b_d = b_q[i*4 +: 4];
            end
        end
        raw     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, carry_q};
        bad     = (a_d > 4'd9) || (b_d > 4'd9);
        digit   = raw[3:0];
        carry_n = 1'b0;
        if (raw > 5'd9) begin
            // (raw + 6) mod 16 only depends on the low nibble of raw
            digit   = raw[3:0] + 4'd6;
            carry_n = 1'b1;
        end
    end

    // Operand latch, digit-serial datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        error_q <= 1'b0;
                    end
                end
                ADD: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (idx_q == 3'(i)) sum_q[i*4 +: 4] <= digit;
                    end
                    carry_q <= carry_n;
                    idx_q   <= idx_q + 3'd1;
                    if (bad) error_q <= 1'b1;
                    if (idx_q == LAST) cout_q <= carry_n;
                end
                default: ;
            endcase
        end
    end

    // done is registered so it rises the cycle after DONE, once the result has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= (state_q == DONE);
    end

    // Seven-segment decode of the selected sum digit; out-of-range selects blank
    always_comb begin
        seg_digit = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (disp_sel == 3'(i)) seg_digit = sum_q[i*4 +: 4];
        end
        seg = 7'h00;
        if ({1'b0, disp_sel} < ND4) begin
            case (seg_digit)
                4'd0:    seg = 7'h3F;
                4'd1:    seg = 7'h06;
                4'd2:    seg = 7'h5B;
                4'd3:    seg = 7'h4F;
                4'd4:    seg = 7'h66;
                4'd5:    seg = 7'h6D;
                4'd6:    seg = 7'h7D;
                4'd7:    seg = 7'h07;
                4'd8:    seg = 7'h7F;
                4'd9:    seg = 7'h6F;
                default: seg = 7'h79;
            endcase
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign error = error_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder (NDIGITS=4): directed scenarios plus a
// randomized back-to-back run checked against a digit-rule reference model.
module tb_bcd_serial_adder;

    logic        clk, rst_n, start, cin;
    logic [15:0] a, b;
    logic [2:0]  disp_sel;
    logic        busy, done, cout, error;
    logic [15:0] sum;
    logic [6:0]  seg;

    int errors = 0;
    int checks = 0;

    bcd_serial_adder #(.NDIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .disp_sel(disp_sel), .busy(busy), .done(done), .sum(sum),
        .cout(cout), .error(error), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: digit-wise decimal addition with the +6 correction rule.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic mc, output logic [15:0] s,
                                  output logic co, output logic er);
        int c = int'(mc);
        s  = '0;
        er = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int ad = int'(ma[i*4 +: 4]);
            int bd = int'(mb[i*4 +: 4]);
            int r  = ad + bd + c;
            if (ad > 9 || bd > 9) er = 1'b1;
            if (r > 9) begin
                s[i*4 +: 4] = 4'((r + 6) % 16);
                c = 1;
            end else begin
                s[i*4 +: 4] = 4'(r);
                c = 0;
            end
        end
        co = 1'(c);
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    function automatic logic [15:0] rand_operand(input bit allow_bad);
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            if (allow_bad && ($urandom_range(0, 7) == 0)) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else                                          v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Starts one addition, scrambles inputs after acceptance, waits for done
    // (bounded) and reports latency plus done level one cycle later.
    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           output int lat, output logic busy_seen, output logic done_after);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_seen = busy;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; disp_sel = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sum, cout, error} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b error=%b, want all 0",
                     busy, done, sum, cout, error);
        end
        checks++;
        if (seg !== 7'h3F) begin
            errors++;
            $display("FAIL reset_seg0: got %h want 3f", seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat; logic bs, da;
        run_add(16'h1234, 16'h5678, 1'b0, lat, bs, da);
        checks++;
        if (sum !== 16'h6912 || cout !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got sum=%h cout=%b error=%b want 6912/0/0", sum, cout, error);
        end
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 5", lat);
        end
        checks++;
        if (bs !== 1'b1 || da !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_pulse: got busy=%b done_next=%b want 1/0", bs, da);
        end
        disp_sel = 3'd3; #1;
        checks++;
        if (seg !== 7'h7D) begin
            errors++;
            $display("FAIL basic_seg3: got %h want 7d", seg);
        end
    endtask

    task automatic test_carry;
        int lat; logic bs, da;
        run_add(16'h9999, 16'h0001, 1'b0, lat, bs, da);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL carry_result: got sum=%h cout=%b error=%b want 0000/1/0", sum, cout, error);
        end
        disp_sel = 3'd0; #1;
        checks++;
        if (seg !== 7'h3F) begin
            errors++;
            $display("FAIL carry_seg0: got %h want 3f", seg);
        end
    endtask

    task automatic test_cin;
        int lat; logic bs, da;
        run_add(16'h0000, 16'h0000, 1'b1, lat, bs, da);
        checks++;
        if (sum !== 16'h0001 || cout !== 1'b0) begin
            errors++;
            $display("FAIL cin_small: got sum=%h cout=%b want 0001/0", sum, cout);
        end
        run_add(16'h4999, 16'h5000, 1'b1, lat, bs, da);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL cin_ripple: got sum=%h cout=%b want 0000/1", sum, cout);
        end
    endtask

    task automatic test_error;
        int lat; logic bs, da;
        logic [15:0] es; logic eco, eer;
        run_add(16'h00A5, 16'h0003, 1'b0, lat, bs, da);
        model(16'h00A5, 16'h0003, 1'b0, es, eco, eer);
        checks++;
        if (error !== 1'b1 || sum[3:0] !== 4'd8 || sum !== es || cout !== eco) begin
            errors++;
            $display("FAIL error_flag: got error=%b sum=%h cout=%b want 1/%h/%b", error, sum, cout, es, eco);
        end
        // error must stay put while idle
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (error !== 1'b1 || sum !== es) begin
            errors++;
            $display("FAIL error_hold: got error=%b sum=%h want 1/%h", error, sum, es);
        end
        // a digit sum of 20 corrects to 10, which displays as E
        run_add(16'h000F, 16'h0005, 1'b0, lat, bs, da);
        disp_sel = 3'd0; #1;
        checks++;
        if (sum[3:0] !== 4'hA || seg !== 7'h79) begin
            errors++;
            $display("FAIL error_seg_e: got digit=%h seg=%h want a/79", sum[3:0], seg);
        end
        run_add(16'h0012, 16'h0034, 1'b0, lat, bs, da);
        checks++;
        if (error !== 1'b0 || sum !== 16'h0046) begin
            errors++;
            $display("FAIL error_clear: got error=%b sum=%h want 0/0046", error, sum);
        end
    endtask

    task automatic test_ignore_start;
        int pulses = 0;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 16'h8888; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_done_count: got %0d want 1", pulses);
        end
        checks++;
        if (sum !== 16'h3333 || cout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: got sum=%h cout=%b busy=%b want 3333/0/0", sum, cout, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat; logic bs, da;
        logic [15:0] ta, tbv, es; logic tc, eco, eer;
        int sel;
        for (int n = 0; n < 40; n++) begin
            ta  = rand_operand(n % 3 == 0);
            tbv = rand_operand(n % 5 == 0);
            tc  = 1'($urandom);
            model(ta, tbv, tc, es, eco, eer);
            run_add(ta, tbv, tc, lat, bs, da);
            checks++;
            if (sum !== es || cout !== eco || error !== eer || lat !== 5 || da !== 1'b0) begin
                errors++;
                $display("FAIL rand_add[%0d]: a=%h b=%h cin=%b got sum=%h cout=%b err=%b lat=%0d want %h/%b/%b/5",
                         n, ta, tbv, tc, sum, cout, error, lat, es, eco, eer);
            end
            sel = $urandom_range(0, 7);
            disp_sel = 3'(sel); #1;
            checks++;
            if (seg !== ((sel < 4) ? seg_of(int'(es[sel*4 +: 4])) : 7'h00)) begin
                errors++;
                $display("FAIL rand_seg[%0d]: sel=%0d got %h", n, sel, seg);
            end
        end
    endtask

    task automatic test_reset_mid;
        int lat; logic bs, da;
        int pulses = 0;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        disp_sel = 3'd5;
        #1;
        checks++;
        if (busy !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b sum=%h cout=%b error=%b done=%b want 0",
                     busy, sum, cout, error, done);
        end
        checks++;
        if (seg !== 7'h00) begin
            errors++;
            $display("FAIL midreset_seg5: got %h want 00", seg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d pulses want 0", pulses);
        end
        run_add(16'h0505, 16'h0505, 1'b0, lat, bs, da);
        checks++;
        if (sum !== 16'h1010 || lat !== 5) begin
            errors++;
            $display("FAIL midreset_restart: got sum=%h lat=%0d want 1010/5", sum, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_cin();
        test_error();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
